// File: rtl/biriscv_bpred.sv
// Branch predictor: fully associative BTB, bimodal BHT and return address stack.
// Predicts the next fetch PC and trains from registered execute-stage resolutions.
module biriscv_bpred #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_BHT_ENTRIES = 512,
    parameter int RAS_DEPTH       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_f_i,
    input  logic        branch_request_i,
    input  logic        branch_is_taken_i,
    input  logic        branch_is_not_taken_i,
    input  logic [31:0] branch_source_i,
    input  logic [31:0] branch_pc_i,
    input  logic        branch_is_call_i,
    input  logic        branch_is_ret_i,
    input  logic        branch_is_jmp_i,
    output logic [31:0] next_pc_f_o,
    output logic        next_taken_f_o
);

    localparam int BTB_W = $clog2(NUM_BTB_ENTRIES);
    localparam int BHT_W = $clog2(NUM_BHT_ENTRIES);
    localparam int RAS_W = $clog2(RAS_DEPTH);

    logic              btb_valid  [NUM_BTB_ENTRIES];
    logic [31:0]       btb_pc     [NUM_BTB_ENTRIES];
    logic [31:0]       btb_target [NUM_BTB_ENTRIES];
    logic              btb_call   [NUM_BTB_ENTRIES];
    logic              btb_ret    [NUM_BTB_ENTRIES];
    logic              btb_jmp    [NUM_BTB_ENTRIES];
    logic [BTB_W-1:0]  btb_repl;

    logic [1:0]        bht [NUM_BHT_ENTRIES];

    logic [31:0]       ras [RAS_DEPTH];
    logic [RAS_W-1:0]  ras_top;
    logic [RAS_W:0]    ras_count;

    logic              look_hit;
    logic [BTB_W-1:0]  look_idx;
    logic              train_hit;
    logic [BTB_W-1:0]  train_idx;

    logic              resolve;
    logic              btb_wr;
    logic [BTB_W-1:0]  btb_wr_idx;
    logic [BHT_W-1:0]  bht_look_idx;
    logic [BHT_W-1:0]  bht_train_idx;
    logic              ras_push;
    logic              ras_pop;
    logic [RAS_W-1:0]  ras_top_inc;

    // Associative searches for the fetch PC and for the resolving branch.
    always_comb begin
        look_hit  = 1'b0;
        look_idx  = '0;
        train_hit = 1'b0;
        train_idx = '0;
        for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
            if (btb_valid[i] && btb_pc[i] == pc_f_i) begin
                look_hit = 1'b1;
                look_idx = BTB_W'(i);
            end
            if (btb_valid[i] && btb_pc[i] == branch_source_i) begin
                train_hit = 1'b1;
                train_idx = BTB_W'(i);
            end
        end
    end

    assign bht_look_idx  = pc_f_i[2 +: BHT_W];
    assign bht_train_idx = branch_source_i[2 +: BHT_W];

    always_comb begin
        next_pc_f_o    = pc_f_i + 32'd4;
        next_taken_f_o = 1'b0;
        if (look_hit) begin
            if (btb_ret[look_idx]) begin
                next_taken_f_o = 1'b1;
                next_pc_f_o    = (ras_count != '0) ? ras[ras_top] : btb_target[look_idx];
            end else if (btb_call[look_idx] || btb_jmp[look_idx]) begin
                next_taken_f_o = 1'b1;
                next_pc_f_o    = btb_target[look_idx];
            end else if (bht[bht_look_idx][1]) begin
                next_taken_f_o = 1'b1;
                next_pc_f_o    = btb_target[look_idx];
            end
        end
    end

    // A request with no outcome flag carries no information and is ignored.
    assign resolve     = branch_request_i && (branch_is_taken_i || branch_is_not_taken_i);
    assign btb_wr      = resolve && (train_hit || branch_is_taken_i);
    assign btb_wr_idx  = train_hit ? train_idx : btb_repl;
    assign ras_push    = resolve && branch_is_call_i;
    assign ras_pop     = resolve && branch_is_ret_i && !branch_is_call_i && (ras_count != '0);
    assign ras_top_inc = ras_top + RAS_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
            btb_repl <= '0;
        end else if (btb_wr) begin
            btb_valid[btb_wr_idx] <= 1'b1;
            if (!train_hit) begin
                btb_repl <= btb_repl + BTB_W'(1);
            end
        end
    end

    // Entry payload is gated by the valid bit, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (btb_wr) begin
            btb_pc[btb_wr_idx]   <= branch_source_i;
            btb_call[btb_wr_idx] <= branch_is_call_i;
            btb_ret[btb_wr_idx]  <= branch_is_ret_i;
            btb_jmp[btb_wr_idx]  <= branch_is_jmp_i;
            if (branch_is_taken_i) begin
                btb_target[btb_wr_idx] <= branch_pc_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (resolve && !branch_is_call_i && !branch_is_ret_i && !branch_is_jmp_i) begin
            if (branch_is_taken_i) begin
                if (bht[bht_train_idx] != 2'b11) begin
                    bht[bht_train_idx] <= bht[bht_train_idx] + 2'b01;
                end
            end else if (bht[bht_train_idx] != 2'b00) begin
                bht[bht_train_idx] <= bht[bht_train_idx] - 2'b01;
            end
        end
    end

    // A push onto a full stack silently overwrites the oldest return address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ras_top   <= '0;
            ras_count <= '0;
        end else if (ras_push) begin
            ras_top <= ras_top_inc;
            if (ras_count != (RAS_W+1)'(RAS_DEPTH)) begin
                ras_count <= ras_count + (RAS_W+1)'(1);
            end
        end else if (ras_pop) begin
            ras_top   <= ras_top - RAS_W'(1);
            ras_count <= ras_count - (RAS_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (ras_push) begin
            ras[ras_top_inc] <= branch_source_i + 32'd4;
        end
    end

endmodule
